muldiv_seq: RTL and testbench

- Iterative multi-cycle M-extension execution unit plus its sequencing controller.
- Replaces the single-cycle combinational MUL/DIV path of the RV32IM core.
- The core presents funct3 and operands through a valid/ready handshake, stalls its PC while the unit is busy, and writes back resp_data on the one-cycle resp_valid pulse.
- Implements the RISC-V divide-by-zero and signed-overflow results without iterating.

---
 rtl/muldiv_seq.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension unit: radix-2 shift-add multiply and restoring
// divide, one step per clock, behind a valid/ready request and a resp_valid pulse.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         f3_q, f3_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;

    // Sign fix-up and result selection from the final working register.
    function automatic logic [WIDTH-1:0] fixup(input logic [2:0] f3,
                                               input logic neg,
                                               input logic [2*WIDTH-1:0] w);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   quo;
        logic [WIDTH-1:0]   rem;
        prod = neg ? -w : w;
        quo  = neg ? -w[WIDTH-1:0] : w[WIDTH-1:0];
        rem  = neg ? -w[2*WIDTH-1:WIDTH] : w[2*WIDTH-1:WIDTH];
        case (f3)
            3'b000:         return w[WIDTH-1:0];
            3'b100, 3'b101: return quo;
            3'b110, 3'b111: return rem;
            default:        return prod[2*WIDTH-1:WIDTH];
        endcase
    endfunction

    logic             is_div;
    logic             a_signed, b_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             res_neg;
    logic             spec_hit;
    logic [WIDTH-1:0] spec_res;
    logic             div_zero, div_ovf;

    always_comb begin
        is_div   = f3_q[2];
        a_signed = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
        b_signed = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
        a_neg    = a_signed && a_q[WIDTH-1];
        b_neg    = b_signed && b_q[WIDTH-1];
        mag_a    = a_neg ? -a_q : a_q;
        mag_b    = b_neg ? -b_q : b_q;
        case (f3_q)
            3'b001, 3'b100: res_neg = a_neg ^ b_neg;
            3'b010, 3'b110: res_neg = a_neg;
            default:        res_neg = 1'b0;
        endcase

        div_zero = is_div && (b_q == '0);
        div_ovf  = ((f3_q == 3'b100) || (f3_q == 3'b110))
                   && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        spec_hit = div_zero || div_ovf;
        if (div_zero)
            spec_res = f3_q[1] ? a_q : '1;
        else
            spec_res = f3_q[1] ? '0 : a_q;
    end

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] step_next;

    // Work register: multiply keeps {partial high, shifting multiplier};
    // divide keeps {remainder, dividend shifting into quotient}.
    always_comb begin
        add_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        fits    = ~diff[WIDTH];
        if (is_div)
            step_next = {(fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                         work_q[WIDTH-2:0], fits};
        else
            step_next = {add_sum, work_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        a_d          = a_q;
        b_d          = b_q;
        opnd_d       = opnd_q;
        work_d       = work_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    f3_d    = funct3;
                    a_d     = op_a;
                    b_d     = op_b;
                    cnt_d   = '0;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (spec_hit) begin
                    // Special results take a second PREP cycle so they land two cycles after acceptance.
                    if (cnt_q == '0) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = spec_res;
                        state_d      = DONE;
                    end
                end else begin
                    neg_d   = res_neg;
                    opnd_d  = is_div ? mag_b : mag_a;
                    work_d  = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    work_d = step_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = fixup(f3_q, neg_q, step_next);
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            f3_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            opnd_q       <= '0;
            work_q       <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            a_q          <= a_d;
            b_q          <= b_d;
            opnd_q       <= opnd_d;
            work_q       <= work_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latencies, flush,
// asynchronous reset and back-to-back handshake.
module tb_muldiv_seq;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for resp_valid and check latency and data.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input int exp_lat);
        int lat;
        @(negedge clock);
        req_valid = 1'b1;
        funct3    = f3;
        op_a      = a;
        op_b      = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, resp_data, exp_d);
        @(posedge clock);
        #1;
        check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        funct3    = 3'b000;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);
        run_op("div_zero", 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
        run_op("remu_zero", 3'b111, 32'd5,       32'd0,        32'd5,        2);

        // Flush during the 10th ITER cycle (between E10 and E11).
        @(negedge clock);
        req_valid = 1'b1;
        funct3    = 3'b000;
        op_a      = 32'd5;
        op_b      = 32'd6;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(req_ready), 32'd1);
        check("flush_no_resp", 32'(resp_valid), 32'd0);
        check("flush_data_held", resp_data, 32'd5);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset mid-ITER.
        @(negedge clock);
        req_valid = 1'b1;
        funct3    = 3'b011;
        op_a      = 32'd9;
        op_b      = 32'd9;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_resp_data", resp_data, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (resp_valid) seen++;
        end
        check("arst_no_resp", 32'(seen), 32'd0);

        // req_valid held through DONE: accepted only at the first IDLE edge.
        @(negedge clock);
        req_valid = 1'b1;
        funct3    = 3'b000;
        op_a      = 32'd2;
        op_b      = 32'd3;
        @(posedge clock);
        #1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        lat = 0;
        while (!resp_valid && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_first_data", resp_data, 32'd6);
        check("b2b_done_ready", 32'(req_ready), 32'd0);
        @(posedge clock);
        #1;
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        check("b2b_accept_ready", 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("b2b_second_latency", 32'(lat), 32'd33);
        check("b2b_second_data", resp_data, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
